// File: rtl/bus_arbiter.sv
// Cycle-level bus arbiter between the 6502 core and one DMA requester.
// Stalls the core with a fixed rdy lead, grants a bounded burst, then returns the bus with a minimum CPU window.
module bus_arbiter #(
  parameter int STALL_CYCLES = 3,
  parameter int MAX_BURST    = 40,
  parameter int MIN_CPU      = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic dma_req,
  output logic dma_gnt,
  output logic rdy,
  output logic aec,
  output logic busy
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int GAP_W   = (MIN_CPU > 0) ? $clog2(MIN_CPU + 1) : 1;

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYCLES);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(MIN_CPU);
  localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);

  typedef enum logic [2:0] {
    S_CPU     = 3'd0,
    S_STALL   = 3'd1,
    S_TURN    = 3'd2,
    S_DMA     = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic               rdy_q,   rdy_d;
  logic               aec_q,   aec_d;
  logic               gnt_q,   gnt_d;
  logic               busy_q,  busy_d;

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_CPU: begin
        if (gap_q != '0) gap_d = gap_q - GAP_ONE;
        // The first CPU cycle after RELEASE counts toward the window, so the
        // request is accepted on the cycle the gap would reach zero.
        if (dma_req && (gap_q <= GAP_ONE)) begin
          state_d = S_STALL;
          stall_d = STALL_LOAD;
        end
      end
      S_STALL: begin
        if (stall_q != '0) stall_d = stall_q - STALL_ONE;
        if (!dma_req)                  state_d = S_CPU;
        else if (stall_q <= STALL_ONE) state_d = S_TURN;
      end
      S_TURN: begin
        state_d = S_DMA;
        burst_d = '0;
      end
      S_DMA: begin
        if (!dma_req || (burst_q == BURST_LAST)) state_d = S_RELEASE;
        else                                     burst_d = burst_q + BURST_ONE;
      end
      S_RELEASE: begin
        state_d = S_CPU;
        gap_d   = GAP_LOAD;
      end
      default: state_d = S_CPU;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    rdy_d  = (state_d == S_CPU);
    aec_d  = (state_d == S_CPU) || (state_d == S_STALL);
    gnt_d  = (state_d == S_DMA);
    busy_d = (state_d != S_CPU);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_CPU;
      stall_q <= '0;
      burst_q <= '0;
      gap_q   <= '0;
      rdy_q   <= 1'b1;
      aec_q   <= 1'b1;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      rdy_q   <= rdy_d;
      aec_q   <= aec_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign rdy     = rdy_q;
  assign aec     = aec_q;
  assign dma_gnt = gnt_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: per-cycle expected outputs queued as stimulus is planned,
// then random requests with protocol invariants.
module tb_bus_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic req0, req1;
  logic gnt0, rdy0, aec0, busy0;
  logic gnt1, rdy1, aec1, busy1;

  always #5 clock = ~clock;

  bus_arbiter u0 (
    .clock(clock), .reset(reset), .dma_req(req0),
    .dma_gnt(gnt0), .rdy(rdy0), .aec(aec0), .busy(busy0)
  );

  bus_arbiter #(.STALL_CYCLES(2), .MAX_BURST(5), .MIN_CPU(4)) u1 (
    .clock(clock), .reset(reset), .dma_req(req1),
    .dma_gnt(gnt1), .rdy(rdy1), .aec(aec1), .busy(busy1)
  );

  // {rdy, aec, dma_gnt, busy}
  localparam logic [3:0] O_CPU = 4'b1100;
  localparam logic [3:0] O_STL = 4'b0101;
  localparam logic [3:0] O_TRN = 4'b0001;
  localparam logic [3:0] O_DMA = 4'b0011;
  localparam logic [3:0] O_REL = 4'b0001;

  int tests = 0;
  int fails = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  task automatic exp0(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) q0.push_back(v);
  endtask

  task automatic exp1(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) q1.push_back(v);
  endtask

  task automatic step(input logic r0, input logic r1, input string tag);
    logic [3:0] e;
    req0 = r0;
    req1 = r1;
    @(posedge clock);
    #1;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      tests++;
      assert ({rdy0, aec0, gnt0, busy0} === e) else begin
        fails++;
        $error("FAIL %s u0 rdy/aec/gnt/busy got %b expected %b", tag, {rdy0, aec0, gnt0, busy0}, e);
      end
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      tests++;
      assert ({rdy1, aec1, gnt1, busy1} === e) else begin
        fails++;
        $error("FAIL %s u1 rdy/aec/gnt/busy got %b expected %b", tag, {rdy1, aec1, gnt1, busy1}, e);
      end
    end
  endtask

  initial begin
    logic r;
    logic pa, pg;
    int rl, gl;

    // Reset values
    reset = 1'b1;
    exp0(O_CPU, 1); exp1(O_CPU, 1);
    step(1'b0, 1'b0, "reset");
    reset = 1'b0;
    exp0(O_CPU, 1); exp1(O_CPU, 1);
    step(1'b0, 1'b0, "idle");

    // Request held 12 edges: 3 stall, turn, 8 grant, release, CPU
    exp0(O_STL, 3); exp0(O_TRN, 1); exp0(O_DMA, 8); exp0(O_REL, 1); exp0(O_CPU, 3);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "hold12");
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, "hold12_rel");

    // Held past MAX_BURST: exactly 40 granted, 1 CPU cycle, then re-arbitrate
    exp0(O_STL, 3); exp0(O_TRN, 1); exp0(O_DMA, 40); exp0(O_REL, 1); exp0(O_CPU, 1);
    exp0(O_STL, 3); exp0(O_TRN, 1); exp0(O_DMA, 2);
    for (int i = 0; i < 52; i++) step(1'b1, 1'b0, "maxburst");
    exp0(O_REL, 1); exp0(O_CPU, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "maxburst_rel");

    // Two-cycle pulse aborts during STALL; aec stays high
    exp0(O_STL, 2); exp0(O_CPU, 3);
    step(1'b1, 1'b0, "pulse"); step(1'b1, 1'b0, "pulse");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "pulse_abort");

    // Drop on the last STALL cycle still aborts instead of turning
    exp0(O_STL, 3); exp0(O_CPU, 2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "late_abort");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "late_abort_cpu");

    // Reset during the 5th grant cycle: no RELEASE cycle
    exp0(O_STL, 3); exp0(O_TRN, 1); exp0(O_DMA, 5);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, "pre_reset");
    reset = 1'b1;
    exp0(O_CPU, 1); exp1(O_CPU, 1);
    step(1'b1, 1'b0, "reset_in_grant");
    reset = 1'b0;
    exp0(O_CPU, 1);
    step(1'b0, 1'b0, "after_reset");

    // u1: STALL=2, MAX_BURST=5, MIN_CPU=4 with request held across release
    exp1(O_STL, 2); exp1(O_TRN, 1); exp1(O_DMA, 5); exp1(O_REL, 1); exp1(O_CPU, 4);
    exp1(O_STL, 2); exp1(O_TRN, 1); exp1(O_DMA, 1);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, "min_cpu");
    exp1(O_REL, 1); exp1(O_CPU, 1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "min_cpu_rel");

    // Random requests on u0 with invariants
    r = 1'b0; pa = aec0; pg = gnt0; rl = 0; gl = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) r = ~r;
      step(r, 1'b0, "rnd");
      tests++;
      assert (!(aec0 && gnt0)) else begin
        fails++;
        $error("FAIL rnd_overlap aec=%b gnt=%b expected not both 1", aec0, gnt0);
      end
      if (pa && !aec0) begin
        tests++;
        assert (rl >= 3) else begin
          fails++;
          $error("FAIL rnd_rdy_lead rdy low run %0d expected >= 3", rl);
        end
      end
      if (gnt0 && !pg) begin
        tests++;
        assert (pa === 1'b0) else begin
          fails++;
          $error("FAIL rnd_aec_before_gnt aec %b expected 0", pa);
        end
      end
      if (!gnt0 && pg) begin
        tests++;
        assert (aec0 === 1'b0) else begin
          fails++;
          $error("FAIL rnd_aec_after_gnt aec %b expected 0", aec0);
        end
      end
      gl = gnt0 ? gl + 1 : 0;
      if (gnt0) begin
        tests++;
        assert (gl <= 40) else begin
          fails++;
          $error("FAIL rnd_burst_len run %0d expected <= 40", gl);
        end
      end
      rl = rdy0 ? 0 : rl + 1;
      pa = aec0;
      pg = gnt0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
